// File: rtl/eforth1_pkg.sv
// Shared eForth memory-subsystem definitions: bus geometry, access sizes and
// the mb32 sequencer state set.
package eforth1_pkg;
  localparam int DSZ  = 32;
  localparam int ASZ  = 15;
  localparam int BASZ = ASZ + 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } acc_sz_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC0 = 3'd1,
    ST_ACC1 = 3'd2,
    ST_RLAT = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;
endpackage

// File: rtl/mb32_if.sv
// Word-wide memory bus between the access sequencer (master) and the SPRAM (slave).
interface mb32_if;
  import eforth1_pkg::*;
  logic           we;
  logic [3:0]     bmsk;
  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] vo;

  modport master (output we, output bmsk, output ai, output vi, input vo);
  modport slave  (input we, input bmsk, input ai, input vi, output vo);
endinterface

// File: rtl/mb32_lane.sv
// Byte-lane arithmetic for one access: lane masks, split detection, write-data
// alignment across two words and read-data merge with zero extension.
module mb32_lane
  import eforth1_pkg::*;
(
  input  logic [1:0]     off,
  input  logic [1:0]     sz,
  input  logic [DSZ-1:0] wd,
  input  logic [DSZ-1:0] lo,
  input  logic [DSZ-1:0] hi,
  output logic [3:0]     m0,
  output logic [3:0]     m1,
  output logic           split,
  output logic [DSZ-1:0] v0,
  output logic [DSZ-1:0] v1,
  output logic [DSZ-1:0] rdata
);
  logic [2:0]       nb;
  logic [7:0]       nmask;
  logic [DSZ-1:0]   dmask;
  logic [7:0]       mask_w;
  logic [2*DSZ-1:0] wv;

  always_comb begin
    nb    = 3'd4;
    nmask = 8'h0F;
    dmask = '1;
    case (sz)
      SZ_BYTE: begin nb = 3'd1; nmask = 8'h01; dmask = 32'h0000_00FF; end
      SZ_HALF: begin nb = 3'd2; nmask = 8'h03; dmask = 32'h0000_FFFF; end
      default: ;
    endcase
  end

  assign split  = ({1'b0, off} + nb) > 3'd4;
  // Shifting into a double-width vector yields both word halves at once.
  assign mask_w = nmask << off;
  assign m0     = mask_w[3:0];
  assign m1     = mask_w[7:4];
  assign wv     = {{DSZ{1'b0}}, wd} << {off, 3'b000};
  assign v0     = wv[DSZ-1:0];
  assign v1     = wv[2*DSZ-1:DSZ];
  assign rdata  = DSZ'({hi, lo} >> {off, 3'b000}) & dmask;
endmodule

// File: rtl/mb32_ctl.sv
// Byte/half/word access sequencer in front of the 32-bit SPRAM; splits
// word-crossing accesses into two bus cycles and merges read data.
module mb32_ctl
  import eforth1_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            wr,
  input  logic [1:0]      sz,
  input  logic [BASZ-1:0] ba,
  input  logic [DSZ-1:0]  wd,
  output logic            rdy,
  output logic            ack,
  output logic [DSZ-1:0]  rd,
  mb32_if.master          bus
);
  localparam logic [2:0] IDLE = ST_IDLE;
  localparam logic [2:0] ACC0 = ST_ACC0;
  localparam logic [2:0] ACC1 = ST_ACC1;
  localparam logic [2:0] RLAT = ST_RLAT;
  localparam logic [2:0] DONE = ST_DONE;

  logic [2:0]     state_reg;
  logic           wr_reg;
  logic [1:0]     sz_reg;
  logic [1:0]     off_reg;
  logic [DSZ-1:0] wd_reg;
  logic [DSZ-1:0] lo_reg;
  logic [DSZ-1:0] rd_reg;
  logic           we_reg;
  logic [3:0]     bmsk_reg;
  logic [ASZ-1:0] ai_reg;
  logic [DSZ-1:0] vi_reg;

  logic           idle;
  logic [1:0]     l_off;
  logic [1:0]     l_sz;
  logic [DSZ-1:0] l_wd;
  logic [DSZ-1:0] l_lo;
  logic [DSZ-1:0] l_hi;
  logic [3:0]     m0;
  logic [3:0]     m1;
  logic           split;
  logic [DSZ-1:0] v0;
  logic [DSZ-1:0] v1;
  logic [DSZ-1:0] rdata;

  // In IDLE the lane logic looks at the live request so ACC0 values can be
  // registered on the acceptance edge; afterwards it uses the captured request.
  assign idle  = (state_reg == IDLE);
  assign l_off = idle ? ba[1:0] : off_reg;
  assign l_sz  = idle ? sz : sz_reg;
  assign l_wd  = idle ? wd : wd_reg;
  assign l_lo  = split ? lo_reg : bus.vo;
  assign l_hi  = split ? bus.vo : '0;

  mb32_lane u_lane (
    .off   (l_off),
    .sz    (l_sz),
    .wd    (l_wd),
    .lo    (l_lo),
    .hi    (l_hi),
    .m0    (m0),
    .m1    (m1),
    .split (split),
    .v0    (v0),
    .v1    (v1),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wr_reg    <= 1'b0;
      sz_reg    <= '0;
      off_reg   <= '0;
      wd_reg    <= '0;
      lo_reg    <= '0;
      rd_reg    <= '0;
      we_reg    <= 1'b0;
      bmsk_reg  <= '0;
      ai_reg    <= '0;
      vi_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            wr_reg    <= wr;
            sz_reg    <= sz;
            off_reg   <= ba[1:0];
            wd_reg    <= wd;
            ai_reg    <= ba[BASZ-1:2];
            we_reg    <= wr;
            bmsk_reg  <= wr ? m0 : 4'b0000;
            if (wr) vi_reg <= v0;
            state_reg <= ACC0;
          end
        end
        ACC0: begin
          if (split) begin
            ai_reg    <= ai_reg + 1'b1;
            we_reg    <= wr_reg;
            bmsk_reg  <= wr_reg ? m1 : 4'b0000;
            if (wr_reg) vi_reg <= v1;
            state_reg <= ACC1;
          end else begin
            we_reg    <= 1'b0;
            bmsk_reg  <= '0;
            state_reg <= wr_reg ? DONE : RLAT;
          end
        end
        ACC1: begin
          if (!wr_reg) lo_reg <= bus.vo;
          we_reg    <= 1'b0;
          bmsk_reg  <= '0;
          state_reg <= wr_reg ? DONE : RLAT;
        end
        RLAT: begin
          rd_reg    <= rdata;
          state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rdy      = idle;
  assign ack      = (state_reg == DONE);
  assign rd       = rd_reg;
  assign bus.we   = we_reg;
  assign bus.bmsk = bmsk_reg;
  assign bus.ai   = ai_reg;
  assign bus.vi   = vi_reg;
endmodule

// File: tb/tb_mb32_ctl.sv
// Bench for mb32_ctl: SPRAM slave model on the bus, directed vector table and
// random accesses checked against a byte-addressed reference memory.
module tb_mb32_ctl;
  import eforth1_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req = 1'b0;
  logic            wr  = 1'b0;
  logic [1:0]      sz  = 2'd0;
  logic [BASZ-1:0] ba  = '0;
  logic [DSZ-1:0]  wd  = '0;
  logic            rdy;
  logic            ack;
  logic [DSZ-1:0]  rd;
  logic            mem_clr = 1'b1;

  mb32_if bus_if ();

  mb32_ctl dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .wr  (wr),
    .sz  (sz),
    .ba  (ba),
    .wd  (wd),
    .rdy (rdy),
    .ack (ack),
    .rd  (rd),
    .bus (bus_if.master)
  );

  always #5 clk = ~clk;

  // SPRAM model: byte-masked writes, registered read with one cycle latency
  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32768; i++) mem[i] <= '0;
    end else if (bus_if.we) begin
      for (int i = 0; i < 4; i++)
        if (bus_if.bmsk[i]) mem[bus_if.ai][8*i +: 8] <= bus_if.vi[8*i +: 8];
    end
    bus_if.vo <= mem[bus_if.ai];
  end

  int ack_cnt = 0;
  always @(negedge clk) if (ack === 1'b1) ack_cnt++;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  logic [7:0] ref_mem [0:131071];

  logic        obs_we   [1:2];
  logic [3:0]  obs_m    [1:2];
  logic [14:0] obs_ai   [1:2];
  logic [31:0] obs_vi   [1:2];
  int          got_lat;
  logic [31:0] got_rd;

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic [16:0] a;
    logic [31:0] d;
    logic [14:0] ai0;
    logic [3:0]  m0;
    logic [31:0] vi0;
    logic [14:0] ai1;
    logic [3:0]  m1;
    logic [31:0] vi1;
    int          lat;
    logic [31:0] rdv;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic void ref_write(input logic [1:0] s, input logic [16:0] a, input logic [31:0] d);
    for (int k = 0; k < nbytes(s); k++) ref_mem[17'(a + 17'(k))] = d[8*k +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input logic [1:0] s, input logic [16:0] a);
    logic [31:0] r = '0;
    for (int k = 0; k < nbytes(s); k++) r[8*k +: 8] = ref_mem[17'(a + 17'(k))];
    return r;
  endfunction

  // Issue one request from an IDLE cycle; returns one cycle after ack.
  task automatic access(input logic w, input logic [1:0] s, input logic [16:0] a,
                        input logic [31:0] d, input bit hold);
    bit busy_ok = 1'b1;
    bit done    = 1'b0;
    req = 1'b1; wr = w; sz = s; ba = a; wd = d;
    @(posedge clk); #1;
    n_acc++;
    got_lat = 0;
    got_rd  = '0;
    for (int c = 1; c <= 8 && !done; c++) begin
      if (c <= 2) begin
        obs_we[c] = bus_if.we;
        obs_m[c]  = bus_if.bmsk;
        obs_ai[c] = bus_if.ai;
        obs_vi[c] = bus_if.vi;
      end
      if (rdy !== 1'b0) busy_ok = 1'b0;
      if (ack === 1'b1) begin
        got_lat = c;
        got_rd  = rd;
        done    = 1'b1;
      end
      req = hold && !done;
      if (req) begin
        wr = 1'($urandom);
        sz = 2'($urandom);
        ba = 17'($urandom);
        wd = $urandom;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack want ack within 8 cycles (ba=%0h)", a);
    end
    chk("rdy_low_while_busy", 64'(busy_ok), 64'd1);
    chk("idle_after_ack", 64'({rdy, ack}), 64'b10);
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ref_mem[i] = 8'h00;

    vecs[0]  = '{1'b1, 2'd2, 17'h00010, 32'hDEADBEEF, 15'h0004, 4'hF, 32'hDEADBEEF, 15'h0, 4'h0, 32'h0,        2, 32'h0};
    vecs[1]  = '{1'b1, 2'd0, 17'h00013, 32'h000000A5, 15'h0004, 4'h8, 32'hA5000000, 15'h0, 4'h0, 32'h0,        2, 32'h0};
    vecs[2]  = '{1'b1, 2'd2, 17'h00006, 32'h11223344, 15'h0001, 4'hC, 32'h33440000, 15'h2, 4'h3, 32'h00001122, 3, 32'h0};
    vecs[3]  = '{1'b0, 2'd2, 17'h00006, 32'h0,        15'h0001, 4'h0, 32'h0,        15'h2, 4'h0, 32'h0,        4, 32'h11223344};
    vecs[4]  = '{1'b0, 2'd1, 17'h00007, 32'h0,        15'h0001, 4'h0, 32'h0,        15'h2, 4'h0, 32'h0,        4, 32'h00002233};
    vecs[5]  = '{1'b0, 2'd0, 17'h00008, 32'h0,        15'h0002, 4'h0, 32'h0,        15'h0, 4'h0, 32'h0,        3, 32'h00000022};
    vecs[6]  = '{1'b0, 2'd2, 17'h00010, 32'h0,        15'h0004, 4'h0, 32'h0,        15'h0, 4'h0, 32'h0,        3, 32'hA5ADBEEF};
    vecs[7]  = '{1'b1, 2'd1, 17'h00021, 32'h0000BEEF, 15'h0008, 4'h6, 32'h00BEEF00, 15'h0, 4'h0, 32'h0,        2, 32'h0};
    vecs[8]  = '{1'b0, 2'd3, 17'h00020, 32'h0,        15'h0008, 4'h0, 32'h0,        15'h0, 4'h0, 32'h0,        3, 32'h00BEEF00};
    vecs[9]  = '{1'b1, 2'd2, 17'h1FFFE, 32'hCAFEF00D, 15'h7FFF, 4'hC, 32'hF00D0000, 15'h0, 4'h3, 32'h0000CAFE, 3, 32'h0};
    vecs[10] = '{1'b0, 2'd2, 17'h1FFFE, 32'h0,        15'h7FFF, 4'h0, 32'h0,        15'h0, 4'h0, 32'h0,        4, 32'hCAFEF00D};

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset_rdy", 64'(rdy), 64'd1);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_rd", 64'(rd), 64'd0);
    chk("reset_bus", 64'({bus_if.we, bus_if.bmsk, bus_if.ai, bus_if.vi}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    mem_clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      bit sp;
      access(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, 1'b0);
      sp = (vecs[i].lat == (vecs[i].w ? 3 : 4));
      chk($sformatf("v%0d_lat", i), 64'(got_lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_acc0", i), 64'({obs_we[1], obs_ai[1], obs_m[1]}),
          64'({vecs[i].w, vecs[i].ai0, vecs[i].m0}));
      if (vecs[i].w) chk($sformatf("v%0d_vi0", i), 64'(obs_vi[1]), 64'(vecs[i].vi0));
      if (sp) begin
        chk($sformatf("v%0d_acc1", i), 64'({obs_we[2], obs_ai[2], obs_m[2]}),
            64'({vecs[i].w, vecs[i].ai1, vecs[i].m1}));
        if (vecs[i].w) chk($sformatf("v%0d_vi1", i), 64'(obs_vi[2]), 64'(vecs[i].vi1));
      end else begin
        chk($sformatf("v%0d_bus_idle", i), 64'({obs_we[2], obs_m[2]}), 64'd0);
      end
      if (vecs[i].w) ref_write(vecs[i].s, vecs[i].a, vecs[i].d);
      else chk($sformatf("v%0d_rd", i), 64'(got_rd), 64'(vecs[i].rdv));
    end

    // req held high throughout a busy split read: must be taken once only
    access(1'b0, 2'd2, 17'h00006, 32'h0, 1'b1);
    chk("hold_lat", 64'(got_lat), 64'd4);
    chk("hold_rd", 64'(got_rd), 64'h11223344);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_single_ack", 64'(ack_cnt), 64'(n_acc));

    // Reset during ACC1 of a split write aborts it without an ack
    req = 1'b1; wr = 1'b1; sz = 2'd2; ba = 17'h00101; wd = 32'h55667788;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rst_acc0", 64'({bus_if.we, bus_if.ai, bus_if.bmsk}), 64'({1'b1, 15'h0040, 4'hE}));
    @(posedge clk); #1;
    chk("rst_acc1", 64'({bus_if.we, bus_if.ai, bus_if.bmsk}), 64'({1'b1, 15'h0041, 4'h1}));
    rst = 1'b1;
    #1;
    chk("rst_async_bus", 64'({bus_if.we, bus_if.bmsk}), 64'd0);
    chk("rst_async_rdy", 64'(rdy), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_release", 64'({rdy, ack}), 64'b10);
    chk("rst_no_ack", 64'(ack_cnt), 64'(n_acc));

    // Random accesses against the byte-addressed reference memory
    for (int i = 0; i < 60; i++) begin
      logic        w;
      logic [1:0]  s;
      logic [16:0] a;
      logic [31:0] d;
      int          n;
      int          exp_lat;
      w = 1'($urandom);
      s = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFF0 + $urandom_range(0, 15))
                                      : 17'($urandom_range(0, 63));
      d = $urandom;
      n = nbytes(s);
      exp_lat = 2 + ((int'(a[1:0]) + n > 4) ? 1 : 0) + (w ? 0 : 1);
      access(w, s, a, d, 1'b0);
      chk($sformatf("r%0d_lat", i), 64'(got_lat), 64'(exp_lat));
      chk($sformatf("r%0d_ai0", i), 64'(obs_ai[1]), 64'(a[16:2]));
      if (w) ref_write(s, a, d);
      else chk($sformatf("r%0d_rd", i), 64'(got_rd), 64'(ref_read(s, a)));
    end

    chk("final_ack_count", 64'(ack_cnt), 64'(n_acc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mb32_ctl.md
Name: mb32_ctl

Overview:
- Memory access sequencer sitting directly upstream of the 32-bit SPRAM memory block; drives the master side of the memory-bus interface.
- Accepts byte, halfword and word read/write requests at byte addresses from the eForth core.
- Converts each request into one or two 32-bit word bus cycles with per-byte write masks.
- Splits accesses that cross a word boundary, then merges and zero-extends read data before returning it to the core.

Parameters:
- DSZ, 32, bus data width in bits; only 32 is supported.
- ASZ, 15, word address width (20 - log2(DSZ), 128K SPRAM).
- BASZ, ASZ+2, byte address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  1  request strobe from core; sampled only while rdy=1
- wr  in  1  1 = write, 0 = read
- sz  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- ba  in  BASZ  byte address, little-endian
- wd  in  DSZ  write data, right-justified
- rdy  out  1  sequencer idle, request will be accepted
- ack  out  1  one-cycle completion pulse
- rd  out  DSZ  read data, zero-extended; valid while ack=1, held until the next read completes
- we  out  1  bus write enable
- bmsk  out  4  bus byte-lane enable; bit i=1 selects vi[8i+7:8i]
- ai  out  ASZ  bus word address
- vi  out  DSZ  bus write data
- vo  in  DSZ  bus read data; valid the cycle after its address is presented (1-cycle latency)
- Bus-side ports map one-to-one onto the memory-bus master modport.

Behaviour:
- Reset (async, rst=1): state IDLE; we=0, bmsk=0, ai=0, vi=0, rd=0, ack=0, rdy=1.
  - Reset mid-operation aborts the access; we and bmsk drop immediately; no ack is issued.
- States: IDLE, ACC0, ACC1, RLAT, DONE.
  - rdy=1 only in IDLE; ack=1 only in DONE.
- Acceptance: in IDLE with req=1, capture wr/sz/ba/wd at the clock edge and go to ACC0. req is ignored in every other state.
- Derived values:
  - off = ba[1:0]; n = 1<<sz bytes (4 when sz=3); w = ba[BASZ-1:2].
  - split = (off + n > 4).
  - m0 = ((1<<n)-1) << off, truncated to 4 bits.
  - m1 = ((1<<n)-1) >> (4-off).
- ACC0: ai=w, bmsk=m0.
  - Write: we=1, vi = wd << 8*off.
  - Read: we=0, bmsk=0.
  - Next state: split → ACC1; otherwise write → DONE, read → RLAT.
- ACC1: ai = w+1, wrapping modulo 2^ASZ (0x7FFF → 0x0000).
  - Write: we=1, bmsk=m1, vi = wd >> 8*(4-off).
  - Read: we=0, bmsk=0; capture vo as low word.
  - Next state: write → DONE, read → RLAT.
- RLAT: capture vo (high word if split, else low word); we=0, bmsk=0.
  - Form rd = ({hi,lo} >> 8*off) masked to n bytes; upper bytes are 0 (no sign extension).
  - Next state: DONE.
- DONE: ack=1 for one cycle, then IDLE. A new req is accepted in the next IDLE cycle, not in DONE.
- Outside ACC0/ACC1: we=0, bmsk=0; ai and vi hold their last values.
- Latency, counted from the acceptance edge at the end of cycle N:
  - aligned write: ack in N+2
  - split write: ack in N+3
  - aligned read: ack in N+3
  - split read: ack in N+4

Decomposition:
- Shared eforth1 package holds:
  - the access-size enum (BYTE, HALF, WORD, RSVD)
  - the sequencer state enum
  - DSZ/ASZ constants, matching the interface
- One combinational sub-module, mb32_lane, computes m0, m1, split, the shifted vi words and the read-merge/zero-extend.
- mb32_ctl holds the FSM and registers.

Test Plan:
- Word write, ba=0x00010, wd=0xDEADBEEF, at req in N → N+1: we=1, ai=0x0004, bmsk=1111, vi=0xDEADBEEF; ack=1 in N+2; rdy=0 during N+1..N+2.
- Byte write, ba=0x00013, sz=0, wd=0x000000A5 → single bus cycle: bmsk=1000, vi=0xA5000000; ack in N+2.
- Split word write, ba=0x00006, wd=0x11223344:
  - ACC0: ai=1, bmsk=1100, vi=0x33440000.
  - ACC1: ai=2, bmsk=0011, vi=0x00001122.
  - ack in N+3.
- Read-back after the split write:
  - word at 0x00006 → rd=0x11223344, ack in N+4.
  - half at 0x00007 → rd=0x00002233 (split).
  - byte at 0x00008 → rd=0x00000022, ack in N+3.
- Wrap, word write at ba=0x1FFFE → ACC0: ai=0x7FFF, bmsk=1100; ACC1: ai=0x0000, bmsk=0011.
- Robustness:
  - req held high during a busy access is ignored; exactly one ack per accepted request.
  - rst asserted in ACC1 → we=0, bmsk=0 immediately, no ack; rdy=1 after release.
